// File: rtl/sram_bank_arbiter_pkg.sv
// Shared types and default sizes for the SRAM bank arbiter and its read-return FIFO.
package sram_bank_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FETCH_WIDTH = 4;
  localparam int DEF_OUT_DEPTH   = 2;

  typedef enum logic {
    SEL_WRITE = 1'b0,
    SEL_READ  = 1'b1
  } arb_sel_t;

  typedef logic [DEF_FETCH_WIDTH-1:0][DEF_DATA_WIDTH-1:0] sram_word_t;

endpackage

// File: rtl/sram_bank_arbiter_rd_return_fifo.sv
// In-order read-return buffer; occupancy feeds the arbiter's credit check.
module rd_return_fifo
  import sram_bank_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_FETCH_WIDTH * DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_OUT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign occupancy = count_q;

  // The arbiter's credit accounting must make this unreachable.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between a writer and a
// credit-limited reader whose data returns in order through a small buffer.
module sram_bank_arbiter
  import sram_bank_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int OUT_DEPTH   = DEF_OUT_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clk_en,
  input  logic                                  wr_valid,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] wr_data,
  output logic                                  wr_ready,
  input  logic                                  rd_valid,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  output logic                                  rd_ready,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] rd_data,
  output logic                                  rd_data_valid,
  input  logic                                  rd_data_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr_in_bank,
  output logic                                  mem_cen_in_bank,
  output logic                                  mem_wen_in_bank,
  output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_in_bank,
  input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_out_bank
);

  // Handshake: a request is accepted in the cycle its valid is high and the
  // matching ready is high; ready is combinational from the grant and is
  // never high for both requesters in the same cycle.

  localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;
  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

  arb_sel_t                               rr_last_q;
  logic                                   inflight_q;
  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] wdata_q;

  logic [CNT_W-1:0]  occupancy;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W:0]    in_use;
  logic              credit_ok;
  logic              rd_eligible;
  logic              wr_grant;
  logic              rd_grant;
  logic              push;
  logic              pop;

  assign in_use      = {1'b0, occupancy} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok   = (in_use < (CNT_W + 1)'(OUT_DEPTH));
  assign rd_eligible = rd_valid && credit_ok;

  // rst_n gates the grant so the bank-side outputs drop the moment reset asserts.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (rst_n && clk_en) begin
      if (wr_valid && rd_eligible) begin
        if (rr_last_q == SEL_READ) wr_grant = 1'b1;
        else                       rd_grant = 1'b1;
      end else begin
        wr_grant = wr_valid;
        rd_grant = rd_eligible;
      end
    end
  end

  always_comb begin
    mem_cen_in_bank  = wr_grant || rd_grant;
    mem_wen_in_bank  = wr_grant;
    mem_addr_in_bank = '0;
    if (wr_grant)      mem_addr_in_bank = wr_addr;
    else if (rd_grant) mem_addr_in_bank = rd_addr;
    mem_data_in_bank = wr_grant ? wr_data : wdata_q;
  end

  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= SEL_READ;
      inflight_q <= 1'b0;
      wdata_q    <= '0;
    end else if (clk_en) begin
      inflight_q <= rd_grant;
      if (wr_grant) begin
        rr_last_q <= SEL_WRITE;
        wdata_q   <= wr_data;
      end else if (rd_grant) begin
        rr_last_q <= SEL_READ;
      end
    end
  end

  // The bank shares clk_en, so its output stays valid until the next enabled cycle.
  assign push = clk_en && inflight_q;
  assign pop  = clk_en && !fifo_empty && rd_data_ready;

  rd_return_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (OUT_DEPTH)
  ) u_rd_return_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (mem_data_out_bank),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign rd_data       = fifo_head;
  assign rd_data_valid = !fifo_empty;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter: a bank model, grant and read-data
// scoreboards fed by the stimulus, and directed checks for reset and timing.
module tb_sram_bank_arbiter;
  import sram_bank_arbiter_pkg::*;

  localparam sram_word_t W10 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam sram_word_t W20 = 64'hA020_B020_C020_D020;
  localparam sram_word_t W21 = 64'hA021_B021_C021_D021;
  localparam sram_word_t W30 = 64'h3030_0303_1234_5678;
  localparam sram_word_t W40 = 64'hDEAD_BEEF_0040_4000;
  localparam sram_word_t W50 = 64'h5555_AAAA_5555_AAAA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic       wr_valid;
  logic [7:0] wr_addr;
  sram_word_t wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_addr;
  logic       rd_ready;
  sram_word_t rd_data;
  logic       rd_data_valid;
  logic       rd_data_ready;
  logic [7:0] mem_addr_in_bank;
  logic       mem_cen_in_bank;
  logic       mem_wen_in_bank;
  sram_word_t mem_data_in_bank;
  sram_word_t mem_data_out_bank;

  int n_cmp  = 0;
  int n_fail = 0;

  // Grant entry: {wr_ready, rd_ready, cen, wen, addr, write data or 0}
  logic [75:0] exp_grant_q[$];
  logic [63:0] exp_rd_q[$];

  sram_bank_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clk_en            (clk_en),
    .wr_valid          (wr_valid),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .rd_valid          (rd_valid),
    .rd_addr           (rd_addr),
    .rd_ready          (rd_ready),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .rd_data_ready     (rd_data_ready),
    .mem_addr_in_bank  (mem_addr_in_bank),
    .mem_cen_in_bank   (mem_cen_in_bank),
    .mem_wen_in_bank   (mem_wen_in_bank),
    .mem_data_in_bank  (mem_data_in_bank),
    .mem_data_out_bank (mem_data_out_bank)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Bank model: one-cycle read latency, clocked only on access
  logic [63:0] bank [0:255];
  always @(posedge clk) begin
    if (mem_cen_in_bank) begin
      if (mem_wen_in_bank) bank[mem_addr_in_bank] <= mem_data_in_bank;
      else                 mem_data_out_bank <= bank[mem_addr_in_bank];
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic wv, input logic [7:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [7:0] ra, input logic rdr, input logic en);
    wr_valid = wv;  wr_addr = wa;  wr_data = wd;
    rd_valid = rv;  rd_addr = ra;  rd_data_ready = rdr;
    clk_en = en;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 64'd0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [63:0] d);
    exp_grant_q.push_back({4'b1011, a, d});
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [63:0] d);
    exp_grant_q.push_back({4'b0110, a, 64'd0});
    exp_rd_q.push_back(d);
  endtask

  // Monitor: bank grants, in order
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_cen_in_bank) begin
        if (exp_grant_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_grant: got addr %h wen %b, none expected",
                   mem_addr_in_bank, mem_wen_in_bank);
        end else begin
          check("grant", {4'b0, wr_ready, rd_ready, mem_cen_in_bank, mem_wen_in_bank,
                          mem_addr_in_bank, (mem_wen_in_bank ? mem_data_in_bank : 64'd0)},
                {4'b0, exp_grant_q.pop_front()});
        end
      end else begin
        check("idle_bank", {77'd0, wr_ready, rd_ready, mem_wen_in_bank}, 80'd0);
      end
    end
  end

  // Monitor: returned read data, in order
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clk_en && rd_data_valid && rd_data_ready) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rd_data: got %h, none expected", rd_data);
      end else begin
        check("rd_data", {16'd0, rd_data}, {16'd0, exp_rd_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 8'h55, W50, 1'b1, 8'h55, 1'b1, 1'b1);
    tick();
    // Reset values with requests present
    check("rst_ready", {78'd0, wr_ready, rd_ready}, 80'd0);
    check("rst_bank_ctl", {78'd0, mem_cen_in_bank, mem_wen_in_bank}, 80'd0);
    check("rst_bank_addr", {72'd0, mem_addr_in_bank}, 80'd0);
    check("rst_bank_data", {16'd0, mem_data_in_bank}, 80'd0);
    check("rst_rd_out", {15'd0, rd_data_valid, rd_data}, 80'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Write only
    drive(1'b1, 8'h10, W10, 1'b0, 8'h00, 1'b1, 1'b1);
    exp_wr(8'h10, W10);
    tick();
    // Read after write, 2-cycle return latency
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h10, 1'b1, 1'b1);
    exp_rd(8'h10, W10);
    tick();
    idle();
    #2 check("latency_t1_valid", {79'd0, rd_data_valid}, 80'd0);
    tick();
    #2 check("latency_t2_valid", {79'd0, rd_data_valid}, 80'd1);
    tick();

    // Conflict: W, R, W, R
    drive(1'b1, 8'h20, W20, 1'b1, 8'h20, 1'b1, 1'b1);  exp_wr(8'h20, W20);  tick();
    drive(1'b1, 8'h21, W21, 1'b1, 8'h20, 1'b1, 1'b1);  exp_rd(8'h20, W20);  tick();
    drive(1'b1, 8'h21, W21, 1'b1, 8'h21, 1'b1, 1'b1);  exp_wr(8'h21, W21);  tick();
    drive(1'b1, 8'h22, W50, 1'b1, 8'h21, 1'b1, 1'b1);  exp_rd(8'h21, W21);  tick();
    idle();  tick();
    tick();

    // Backpressure: two credits, then reads stall while writes proceed
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h20, 1'b0, 1'b1);  exp_rd(8'h20, W20);  tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h21, 1'b0, 1'b1);  exp_rd(8'h21, W21);  tick();
    drive(1'b1, 8'h30, W30, 1'b1, 8'h30, 1'b0, 1'b1);  exp_wr(8'h30, W30);
    #2 check("bp_rd_ready_t3", {79'd0, rd_ready}, 80'd0);
    tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h30, 1'b0, 1'b1);
    #2 check("bp_rd_ready_t4", {79'd0, rd_ready}, 80'd0);
    check("bp_full_valid", {79'd0, rd_data_valid}, 80'd1);
    tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h30, 1'b1, 1'b1);
    #2 check("bp_pop_cycle_rd_ready", {79'd0, rd_ready}, 80'd0);
    tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h30, 1'b1, 1'b1);  exp_rd(8'h30, W30);  tick();
    idle();  tick();
    tick();

    // clk_en low for 3 cycles with a read in flight
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h10, 1'b1, 1'b1);  exp_rd(8'h10, W10);  tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h50, W50, 1'b1, 8'h10, 1'b1, 1'b0);
      #2 check("en_low_ready", {78'd0, wr_ready, rd_ready}, 80'd0);
      check("en_low_cen", {79'd0, mem_cen_in_bank}, 80'd0);
      check("en_low_buffer", {79'd0, rd_data_valid}, 80'd0);
      tick();
    end
    idle();
    #2 check("en_resume_capture_pending", {79'd0, rd_data_valid}, 80'd0);
    tick();
    #2 check("en_resume_data", {15'd0, rd_data_valid, rd_data}, {15'd0, 1'b1, W10});
    tick();

    // Reset with one word buffered and one read in flight
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h20, 1'b0, 1'b1);  exp_rd(8'h20, W20);  tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h21, 1'b0, 1'b1);  exp_rd(8'h21, W21);  tick();
    drive(1'b1, 8'h40, W40, 1'b1, 8'h40, 1'b1, 1'b1);
    rst_n = 1'b0;
    exp_rd_q.delete();
    #1;
    check("midrst_ready", {78'd0, wr_ready, rd_ready}, 80'd0);
    check("midrst_bank", {6'd0, mem_cen_in_bank, mem_wen_in_bank, mem_addr_in_bank, mem_data_in_bank}, 80'd0);
    check("midrst_rd_out", {15'd0, rd_data_valid, rd_data}, 80'd0);
    tick();
    tick();
    exp_wr(8'h40, W40);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 8'h00, 64'd0, 1'b1, 8'h40, 1'b1, 1'b1);  exp_rd(8'h40, W40);  tick();
    idle();
    repeat (4) tick();

    check("grant_queue_drained", {48'd0, 32'(exp_grant_q.size())}, 80'd0);
    check("rd_queue_drained", {48'd0, 32'(exp_rd_q.size())}, 80'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
Name: sram_bank_arbiter

Overview:
- Shares one single-port SRAM bank (256 x 4x16-bit words; cen/wen active-high at the bank-wrapper boundary, 1-cycle read latency) between a write requester and a read requester.
- Write requester is the aggregator side; read requester is the transpose-buffer side.
- Grants at most one access per cycle with round-robin on conflict.
- Returns read data in order through a 2-entry output buffer with credit-based issue.

Parameters:
- ADDR_WIDTH, 8, SRAM word address width
- DATA_WIDTH, 16, bits per lane
- FETCH_WIDTH, 4, lanes per SRAM word
- OUT_DEPTH, 2, read-return buffer entries (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- clk_en  in  1  global enable; 0 freezes all state
- wr_valid  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  FETCH_WIDTH x DATA_WIDTH  write word
- wr_ready  out  1  write accepted this cycle
- rd_valid  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_ready  out  1  read accepted this cycle
- rd_data  out  FETCH_WIDTH x DATA_WIDTH  buffer head
- rd_data_valid  out  1  buffer non-empty
- rd_data_ready  in  1  consumer pops head
- mem_addr_in_bank  out  ADDR_WIDTH  to bank wrapper
- mem_cen_in_bank  out  1  bank access enable
- mem_wen_in_bank  out  1  bank write enable
- mem_data_in_bank  out  FETCH_WIDTH x DATA_WIDTH  bank write data
- mem_data_out_bank  in  FETCH_WIDTH x DATA_WIDTH  bank read data, 1 cycle after read issue

Behaviour:
Interface
- One clock, clk; reset rst_n is asynchronous, active-low.
- All state clears immediately on rst_n=0.

Reset values
- wr_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0.
- mem_cen_in_bank=0, mem_wen_in_bank=0, mem_addr_in_bank=0, mem_data_in_bank=0.
- Buffer empty, inflight=0, rr_last=READ, so write wins the first conflict.

Bank-side outputs
- Combinational from the grant. Nothing is registered between the grant and the bank.

Credit
- credit = OUT_DEPTH − occupancy − inflight.
- A read is eligible only when rd_valid=1 and credit>0.

Grant rules (only when clk_en=1)
- Write only: grant write.
- Eligible read only: grant read.
- Both: grant the opposite of rr_last; rr_last updates on every grant.
- No requests: no grant; cen=0 and wen=0.
- Write grant: cen=1, wen=1, addr=wr_addr, data=wr_data, wr_ready=1.
- Read grant: cen=1, wen=0, addr=rd_addr, rd_ready=1.
- When no write is granted, mem_data_in_bank holds its last value. This is don't-care to the bank.
- wr_ready and rd_ready are never both 1 in the same cycle.

Read pipeline
- A read grant sets inflight=1.
- The next enabled cycle captures mem_data_out_bank into the buffer tail and clears inflight.

Output buffer
- FIFO of depth OUT_DEPTH.
- Pop when rd_data_valid && rd_data_ready.
- Push and pop in the same cycle are legal and leave occupancy unchanged.
- The credit rule guarantees no overflow; a push when full is an assertion failure.
- Read latency is 2 cycles, rd_ready to rd_data_valid, when the buffer is empty.
- A full buffer with no pop blocks reads; writes still proceed.

clk_en=0
- No grants; all ready outputs 0; cen=0.
- inflight, buffer, and rr_last are held.
- Capture of a pending read waits for the next clk_en=1 cycle. The bank clock is gated by the same enable, so its output is stable.

Reset mid-operation
- An in-flight read and buffered data are discarded.

Decomposition:
- Shared package holds:
  - `arb_sel_t` enum {SEL_WRITE, SEL_READ}
  - `sram_word_t` typedef (FETCH_WIDTH x DATA_WIDTH)
  - default constants for ADDR_WIDTH, FETCH_WIDTH, DATA_WIDTH
- One sub-module: `rd_return_fifo` (OUT_DEPTH-entry FIFO, exposes occupancy).
- Arbiter and credit logic stay in the top module.

Test Plan:
1. Write only: wr_valid=1, addr 0x10, data {4,3,2,1} → same cycle wr_ready=1, cen=1, wen=1, addr 0x10.
2. Read after write: rd_valid=1, addr 0x10 (bank model returns the stored word) → rd_ready=1 at T, cen=1, wen=0; rd_data_valid=1 with {4,3,2,1} at T+2.
3. Conflict: both valid for 4 cycles, consumer always ready → grants alternate W,R,W,R; the first grant is W after reset.
4. Backpressure: rd_data_ready=0 with continuous rd_valid → exactly 2 reads granted, then rd_ready=0. Writes are still granted in between. Raising rd_data_ready frees one credit per pop.
5. clk_en low for 3 cycles while a read is in flight → no grants, buffer unchanged. Data is captured in the first cycle after clk_en returns to 1, with the correct value.
6. rst_n asserted mid-stream with 1 buffered and 1 in flight → outputs immediately take their reset values, rd_data_valid=0. After release, the first conflict grants write.
